// File: rtl/dcache_tag_write_sched_pkg.sv
// Shared DCache tag-write definitions: default geometry, the write request record
// and a counter-width helper.
package dcache_tag_write_sched_pkg;

   localparam int unsigned IDX_W = 6;
   localparam int unsigned WAYS  = 8;
   localparam int unsigned TAG_W = 24;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic [WAYS-1:0]  way_en;
      logic [TAG_W-1:0] tag;
   } tag_wreq_t;

   // Bits needed to hold a counter that saturates at max_val.
   function automatic int unsigned cnt_w(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/dcache_tag_write_sched_tag_wreq_stage.sv
// One-entry staging register for tag writes. A dequeue and an enqueue may
// happen in the same cycle, so a draining entry is refilled without a bubble.
module dcache_tag_write_sched_tag_wreq_stage #(
   parameter int unsigned W = 38
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         enq_valid,
   output logic         enq_ready,
   input  logic [W-1:0] enq_data,
   output logic         deq_valid,
   input  logic         deq_ready,
   output logic [W-1:0] deq_data
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;
   logic         enq_fire;
   logic         deq_fire;

   always_comb begin
      enq_ready = ~valid_q | deq_ready;
      enq_fire  = enq_valid & enq_ready;
      deq_fire  = valid_q & deq_ready;
      deq_valid = valid_q;
      deq_data  = data_q;
   end

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (enq_fire) begin
         valid_d = 1'b1;
         data_d  = enq_data;
      end else if (deq_fire) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/dcache_tag_write_sched.sv
// Tag/meta SRAM write scheduler: arbitrates refill (port 0) against replace/probe
// (port 1), stages the winner, and slots it into cycles the tag read path leaves free.
module dcache_tag_write_sched #(
   parameter int unsigned IDX_W       = dcache_tag_write_sched_pkg::IDX_W,
   parameter int unsigned WAYS        = dcache_tag_write_sched_pkg::WAYS,
   parameter int unsigned TAG_W       = dcache_tag_write_sched_pkg::TAG_W,
   parameter int unsigned STARVE_MAX  = 4,
   parameter int unsigned RD_HOLD_MAX = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             io_in_0_valid,
   output logic             io_in_0_ready,
   input  logic [IDX_W-1:0] io_in_0_bits_idx,
   input  logic [WAYS-1:0]  io_in_0_bits_way_en,
   input  logic [TAG_W-1:0] io_in_0_bits_tag,
   input  logic             io_in_1_valid,
   output logic             io_in_1_ready,
   input  logic [IDX_W-1:0] io_in_1_bits_idx,
   input  logic [WAYS-1:0]  io_in_1_bits_way_en,
   input  logic [TAG_W-1:0] io_in_1_bits_tag,
   input  logic             io_rd_valid,
   output logic             io_rd_ready,
   output logic             io_sram_wen,
   output logic [IDX_W-1:0] io_sram_idx,
   output logic [WAYS-1:0]  io_sram_way_en,
   output logic [TAG_W-1:0] io_sram_tag,
   output logic             io_busy
);

   import dcache_tag_write_sched_pkg::*;

   localparam int unsigned PW = IDX_W + WAYS + TAG_W;
   localparam int unsigned SW = cnt_w(STARVE_MAX);
   localparam int unsigned HW = cnt_w(RD_HOLD_MAX);

   logic          stg_v;
   logic [PW-1:0] stg_data;
   logic          deq_ready;
   logic          can_acc;
   logic          force_wr;
   logic          force_1;
   logic          write_now;
   logic          sel_1;
   logic          acc_0;
   logic          acc_1;
   logic          enq_valid;
   logic [PW-1:0] enq_data;

   logic [SW-1:0] starve_q, starve_d;
   logic [HW-1:0] hold_q, hold_d;

   always_comb begin
      force_wr  = stg_v & (hold_q == HW'(RD_HOLD_MAX));
      force_1   = (starve_q == SW'(STARVE_MAX));
      // Reads own the array unless the staged write has waited long enough.
      deq_ready = ~io_rd_valid | force_wr;
      write_now = stg_v & deq_ready;
      sel_1     = io_in_1_valid & (force_1 | ~io_in_0_valid);

      io_in_0_ready = can_acc & ~(force_1 & io_in_1_valid);
      io_in_1_ready = can_acc & (force_1 | ~io_in_0_valid);
      acc_0         = io_in_0_valid & io_in_0_ready;
      acc_1         = io_in_1_valid & io_in_1_ready;

      enq_valid = acc_0 | acc_1;
      enq_data  = sel_1 ? {io_in_1_bits_idx, io_in_1_bits_way_en, io_in_1_bits_tag}
                        : {io_in_0_bits_idx, io_in_0_bits_way_en, io_in_0_bits_tag};
   end

   dcache_tag_write_sched_tag_wreq_stage #(
      .W(PW)
   ) u_stage (
      .clock     (clock),
      .reset     (reset),
      .enq_valid (enq_valid),
      .enq_ready (can_acc),
      .enq_data  (enq_data),
      .deq_valid (stg_v),
      .deq_ready (deq_ready),
      .deq_data  (stg_data)
   );

   // Payload comes straight from the staging register; wen collapses with stg_v on reset.
   always_comb begin
      io_sram_wen    = write_now;
      io_sram_idx    = stg_data[PW-1 -: IDX_W];
      io_sram_way_en = stg_data[TAG_W +: WAYS];
      io_sram_tag    = stg_data[TAG_W-1:0];
      io_rd_ready    = ~force_wr;
      io_busy        = stg_v;
   end

   always_comb begin
      starve_d = starve_q;
      if (acc_1) begin
         starve_d = '0;
      end else if (io_in_1_valid && acc_0 && (starve_q != SW'(STARVE_MAX))) begin
         starve_d = starve_q + SW'(1);
      end
   end

   always_comb begin
      hold_d = hold_q;
      if (!stg_v || write_now) begin
         hold_d = '0;
      end else if (hold_q != HW'(RD_HOLD_MAX)) begin
         hold_d = hold_q + HW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         starve_q <= '0;
         hold_q   <= '0;
      end else begin
         starve_q <= starve_d;
         hold_q   <= hold_d;
      end
   end

endmodule

// File: tb/tb_dcache_tag_write_sched.sv
// Bench for dcache_tag_write_sched: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_dcache_tag_write_sched;

   import dcache_tag_write_sched_pkg::*;

   localparam int unsigned STARVE_MAX  = 4;
   localparam int unsigned RD_HOLD_MAX = 8;

   logic             clock;
   logic             reset;
   logic             in0_v, in0_r, in1_v, in1_r;
   logic [IDX_W-1:0] in0_idx, in1_idx, s_idx;
   logic [WAYS-1:0]  in0_way, in1_way, s_way;
   logic [TAG_W-1:0] in0_tag, in1_tag, s_tag;
   logic             rd_v, rd_r, wen, busy;

   int checks = 0;
   int errors = 0;

   dcache_tag_write_sched #(
      .IDX_W(IDX_W), .WAYS(WAYS), .TAG_W(TAG_W),
      .STARVE_MAX(STARVE_MAX), .RD_HOLD_MAX(RD_HOLD_MAX)
   ) dut (
      .clock               (clock),
      .reset               (reset),
      .io_in_0_valid       (in0_v),
      .io_in_0_ready       (in0_r),
      .io_in_0_bits_idx    (in0_idx),
      .io_in_0_bits_way_en (in0_way),
      .io_in_0_bits_tag    (in0_tag),
      .io_in_1_valid       (in1_v),
      .io_in_1_ready       (in1_r),
      .io_in_1_bits_idx    (in1_idx),
      .io_in_1_bits_way_en (in1_way),
      .io_in_1_bits_tag    (in1_tag),
      .io_rd_valid         (rd_v),
      .io_rd_ready         (rd_r),
      .io_sram_wen         (wen),
      .io_sram_idx         (s_idx),
      .io_sram_way_en      (s_way),
      .io_sram_tag         (s_tag),
      .io_busy             (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Directed payloads: port 0 way 0x04 tag 0xABCDEF, port 1 way 0x80 tag 0x123456.
   task automatic drive(input logic v0, input logic v1, input logic rd,
                        input logic [IDX_W-1:0] i0, input logic [IDX_W-1:0] i1);
      in0_v = v0; in0_idx = i0; in0_way = 8'h04; in0_tag = 24'hABCDEF;
      in1_v = v1; in1_idx = i1; in1_way = 8'h80; in1_tag = 24'h123456;
      rd_v  = rd;
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
   endtask

   typedef struct {
      logic             v0, v1, rd;
      logic [IDX_W-1:0] idx;
      logic             e0r, e1r, err, ewen, ebusy;
      logic [IDX_W-1:0] eidx;
      logic             eport;
   } vec_t;

   function automatic vec_t mk(input logic v0, input logic v1, input logic rd,
                               input logic [IDX_W-1:0] idx, input logic e0r,
                               input logic e1r, input logic err, input logic ewen,
                               input logic ebusy, input logic [IDX_W-1:0] eidx,
                               input logic eport);
      vec_t v;
      v.v0 = v0; v.v1 = v1; v.rd = rd; v.idx = idx;
      v.e0r = e0r; v.e1r = e1r; v.err = err; v.ewen = ewen; v.ebusy = ebusy;
      v.eidx = eidx; v.eport = eport;
      return v;
   endfunction

   // Reference model state: accepted-but-unwritten requests in order, age of the
   // oldest, and how many port-0 wins port 1 has sat through.
   tag_wreq_t mq[$];
   int        m_age;
   int        m_losses;

   initial begin
      vec_t tbl[13];
      int   got, expv;

      in0_v = 0; in1_v = 0; rd_v = 0;
      in0_idx = '0; in1_idx = '0; in0_way = '0; in1_way = '0; in0_tag = '0; in1_tag = '0;

      // ---------------- vector table ----------------
      tbl[0]  = mk(0, 0, 0, 6'h00, 1, 1, 1, 0, 0, 6'h00, 0);
      tbl[1]  = mk(1, 0, 0, 6'h15, 1, 0, 1, 0, 0, 6'h00, 0);
      tbl[2]  = mk(0, 0, 0, 6'h00, 1, 1, 1, 1, 1, 6'h15, 0);
      tbl[3]  = mk(0, 0, 0, 6'h00, 1, 1, 1, 0, 0, 6'h00, 0);
      tbl[4]  = mk(1, 0, 0, 6'h01, 1, 0, 1, 0, 0, 6'h00, 0);
      tbl[5]  = mk(1, 0, 0, 6'h02, 1, 0, 1, 1, 1, 6'h01, 0);
      tbl[6]  = mk(1, 0, 0, 6'h03, 1, 0, 1, 1, 1, 6'h02, 0);
      tbl[7]  = mk(0, 0, 0, 6'h00, 1, 1, 1, 1, 1, 6'h03, 0);
      tbl[8]  = mk(0, 0, 0, 6'h00, 1, 1, 1, 0, 0, 6'h00, 0);
      tbl[9]  = mk(0, 1, 0, 6'h2A, 1, 1, 1, 0, 0, 6'h00, 0);
      tbl[10] = mk(0, 0, 1, 6'h00, 0, 0, 1, 0, 1, 6'h00, 0);
      tbl[11] = mk(0, 0, 0, 6'h00, 1, 1, 1, 1, 1, 6'h2A, 1);
      tbl[12] = mk(0, 0, 0, 6'h00, 1, 1, 1, 0, 0, 6'h00, 0);

      apply_reset();
      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].v0, tbl[i].v1, tbl[i].rd, tbl[i].idx, tbl[i].idx);
         @(negedge clock);
         chk($sformatf("tbl%0d_in0_ready", i), in0_r, tbl[i].e0r);
         chk($sformatf("tbl%0d_in1_ready", i), in1_r, tbl[i].e1r);
         chk($sformatf("tbl%0d_rd_ready", i), rd_r, tbl[i].err);
         chk($sformatf("tbl%0d_wen", i), wen, tbl[i].ewen);
         chk($sformatf("tbl%0d_busy", i), busy, tbl[i].ebusy);
         if (tbl[i].ewen) begin
            chk($sformatf("tbl%0d_idx", i), s_idx, tbl[i].eidx);
            chk($sformatf("tbl%0d_way", i), s_way, tbl[i].eport ? 8'h80 : 8'h04);
            chk($sformatf("tbl%0d_tag", i), s_tag, tbl[i].eport ? 24'h123456 : 24'hABCDEF);
         end
         next_cycle();
      end

      // ---------------- both ports valid: port 1 wins every 5th ----------------
      apply_reset();
      drive(1, 1, 0, 6'h05, 6'h06);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         got  = (in1_v && in1_r) ? 1 : ((in0_v && in0_r) ? 0 : 2);
         expv = (i % 5 == 4) ? 1 : 0;
         chk($sformatf("arb_order%0d", i), got, expv);
         next_cycle();
      end

      // ---------------- read stream blocks a staged write ----------------
      apply_reset();
      drive(1, 0, 0, 6'h11, 6'h00);
      next_cycle();
      drive(0, 0, 1, 6'h00, 6'h00);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         chk($sformatf("rdhold%0d_rd_ready", i), rd_r, (i == 8) ? 1'b0 : 1'b1);
         chk($sformatf("rdhold%0d_wen", i), wen, (i == 8) ? 1'b1 : 1'b0);
         if (i == 8) chk("rdhold_idx", s_idx, 6'h11);
         if (i == 9) chk("rdhold_busy_after", busy, 1'b0);
         next_cycle();
      end

      // ---------------- port 1 waits for the forced write ----------------
      apply_reset();
      drive(1, 0, 0, 6'h21, 6'h00);
      next_cycle();
      drive(0, 1, 1, 6'h00, 6'h33);
      for (int i = 0; i < 9; i++) begin
         @(negedge clock);
         chk($sformatf("p1wait%0d_in1_ready", i), in1_r, (i == 8) ? 1'b1 : 1'b0);
         chk($sformatf("p1wait%0d_wen", i), wen, (i == 8) ? 1'b1 : 1'b0);
         next_cycle();
      end
      drive(0, 0, 1, 6'h00, 6'h00);
      @(negedge clock);
      chk("p1wait_busy", busy, 1'b1);
      chk("p1wait_wen_blocked", wen, 1'b0);
      next_cycle();
      drive(0, 0, 0, 6'h00, 6'h00);
      @(negedge clock);
      chk("p1wait_wen", wen, 1'b1);
      chk("p1wait_idx", s_idx, 6'h33);
      next_cycle();

      // ---------------- async reset drops a staged write ----------------
      apply_reset();
      drive(1, 0, 0, 6'h3C, 6'h00);
      next_cycle();
      drive(0, 0, 1, 6'h00, 6'h00);
      repeat (5) next_cycle();
      rd_v  = 1'b0;
      reset = 1'b0;
      #1;
      chk("rst_wen", wen, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rd_ready", rd_r, 1'b1);
      next_cycle();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk($sformatf("post_rst%0d_wen", i), wen, 1'b0);
         chk($sformatf("post_rst%0d_busy", i), busy, 1'b0);
         next_cycle();
      end

      // ---------------- randomized run against the reference model ----------------
      apply_reset();
      mq.delete();
      m_age    = 0;
      m_losses = 0;
      for (int c = 0; c < 3000; c++) begin
         logic      full, fw, wr, room, p1, e0, e1, a0, a1;
         tag_wreq_t r0, r1;
         in0_v   = ($urandom_range(0, 9) < 6);
         in1_v   = ($urandom_range(0, 9) < 5);
         rd_v    = ($urandom_range(0, 9) < ((c < 1500) ? 8 : 3));
         in0_idx = IDX_W'($urandom);
         in1_idx = IDX_W'($urandom);
         in0_way = WAYS'(1) << $urandom_range(0, WAYS - 1);
         in1_way = WAYS'(1) << $urandom_range(0, WAYS - 1);
         in0_tag = TAG_W'($urandom);
         in1_tag = TAG_W'($urandom);
         @(negedge clock);
         full = (mq.size() != 0);
         fw   = full && (m_age >= RD_HOLD_MAX);
         wr   = full && (!rd_v || fw);
         room = !full || wr;
         p1   = (m_losses >= STARVE_MAX);
         e0   = room && !(p1 && in1_v);
         e1   = room && (p1 || !in0_v);
         chk("rnd_in0_ready", in0_r, e0);
         chk("rnd_in1_ready", in1_r, e1);
         chk("rnd_rd_ready", rd_r, !fw);
         chk("rnd_wen", wen, wr);
         chk("rnd_busy", busy, full);
         if (wr) chk("rnd_payload", {s_idx, s_way, s_tag}, mq[0]);
         a0 = in0_v && e0;
         a1 = in1_v && e1;
         r0 = '{idx: in0_idx, way_en: in0_way, tag: in0_tag};
         r1 = '{idx: in1_idx, way_en: in1_way, tag: in1_tag};
         m_age = (full && !wr) ? ((m_age < RD_HOLD_MAX) ? m_age + 1 : m_age) : 0;
         if (wr) void'(mq.pop_front());
         if (a1) mq.push_back(r1);
         else if (a0) mq.push_back(r0);
         if (a1) m_losses = 0;
         else if (in1_v && a0 && m_losses < STARVE_MAX) m_losses++;
         next_cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
